// File: rtl/lc3_pkg.sv
// Shared LC-3 encodings: opcodes, sequencer states, datapath mux selects, CC helpers.
`default_nettype none

package lc3_pkg;

  typedef enum logic [3:0] {
    OP_BR   = 4'h0,
    OP_ADD  = 4'h1,
    OP_LD   = 4'h2,
    OP_ST   = 4'h3,
    OP_JSR  = 4'h4,
    OP_AND  = 4'h5,
    OP_LDR  = 4'h6,
    OP_STR  = 4'h7,
    OP_RTI  = 4'h8,
    OP_NOT  = 4'h9,
    OP_LDI  = 4'hA,
    OP_STI  = 4'hB,
    OP_JMP  = 4'hC,
    OP_RES  = 4'hD,
    OP_LEA  = 4'hE,
    OP_TRAP = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_IND   = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    PC_INC   = 3'd0,
    PC_OFF9  = 3'd1,
    PC_OFF11 = 3'd2,
    PC_BASE  = 3'd3,
    PC_MEM   = 3'd4
  } pc_sel_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC  = 2'd2,
    WB_LEA = 2'd3
  } wb_sel_e;

  typedef enum logic [2:0] {
    A_PC    = 3'd0,
    A_OFF9  = 3'd1,
    A_BASE6 = 3'd2,
    A_MAR   = 3'd3,
    A_TRAP  = 3'd4
  } addr_sel_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_AND = 2'd1,
    ALU_NOT = 2'd2
  } alu_op_e;

  localparam int CC_N = 2;
  localparam int CC_Z = 1;
  localparam int CC_P = 0;

  localparam logic [7:0] TRAP_HALT = 8'h25;
  localparam logic [2:0] CC_RESET  = 3'b010;

  function automatic logic [2:0] nzp(input logic [15:0] v);
    logic [2:0] r;
    r = '0;
    if (v[15])          r[CC_N] = 1'b1;
    else if (v == '0)   r[CC_Z] = 1'b1;
    else                r[CC_P] = 1'b1;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/datapath.sv
// LC-3 datapath: PC, IR, CC, MAR, 8x16 register file, ALU, sign-extenders and unified memory.
`default_nettype none

module datapath
  import lc3_pkg::*;
#(
  parameter int MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld_ir,
  input  logic        ld_pc,
  input  logic        ld_cc,
  input  logic        ld_reg,
  input  logic        ld_mar,
  input  logic        mem_we,
  input  logic        dr_r7,
  input  pc_sel_e     pc_sel,
  input  wb_sel_e     wb_sel,
  input  addr_sel_e   addr_sel,
  input  alu_op_e     alu_op,
  output logic [15:0] ir_out,
  output logic [15:0] pc_out,
  output logic [2:0]  cc_out
);

  localparam int AW = $clog2(MEM_WORDS);

  logic [15:0] ir_q, pc_q, mar_q;
  logic [2:0]  cc_q;
  logic [15:0] rf_q [8];

  logic [2:0]  dr;
  logic [15:0] sr1_val, sr2_val, sr_val;
  logic [15:0] off9, off11, off6, imm5;
  logic [15:0] pc_off9, base_off6;
  logic [15:0] alu_b, alu_y, wb_data, pc_next;
  logic [15:0] mem_addr, mem_rdata;
  logic [AW-1:0] mem_idx;

  assign dr      = dr_r7 ? 3'd7 : ir_q[11:9];
  assign sr1_val = rf_q[ir_q[8:6]];
  assign sr2_val = rf_q[ir_q[2:0]];
  assign sr_val  = rf_q[ir_q[11:9]];

  assign off9  = {{7{ir_q[8]}}, ir_q[8:0]};
  assign off11 = {{5{ir_q[10]}}, ir_q[10:0]};
  assign off6  = {{10{ir_q[5]}}, ir_q[5:0]};
  assign imm5  = {{11{ir_q[4]}}, ir_q[4:0]};

  // pc_q is already incremented by the time EXEC uses these offsets
  assign pc_off9   = pc_q + off9;
  assign base_off6 = sr1_val + off6;

  always_comb begin
    alu_b = ir_q[5] ? imm5 : sr2_val;
    alu_y = ~sr1_val;
    case (alu_op)
      ALU_ADD: alu_y = sr1_val + alu_b;
      ALU_AND: alu_y = sr1_val & alu_b;
      default: alu_y = ~sr1_val;
    endcase
  end

  always_comb begin
    mem_addr = pc_q;
    case (addr_sel)
      A_OFF9:  mem_addr = pc_off9;
      A_BASE6: mem_addr = base_off6;
      A_MAR:   mem_addr = mar_q;
      A_TRAP:  mem_addr = {8'h00, ir_q[7:0]};
      default: mem_addr = pc_q;
    endcase
  end

  assign mem_idx = AW'(32'(mem_addr) % 32'(MEM_WORDS));

  always_comb begin
    wb_data = alu_y;
    case (wb_sel)
      WB_MEM:  wb_data = mem_rdata;
      WB_PC:   wb_data = pc_q;
      WB_LEA:  wb_data = pc_off9;
      default: wb_data = alu_y;
    endcase
  end

  // Targets come from pre-edge register values, so JSRR R7 jumps to the old R7
  always_comb begin
    pc_next = pc_q + 16'd1;
    case (pc_sel)
      PC_OFF9:  pc_next = pc_off9;
      PC_OFF11: pc_next = pc_q + off11;
      PC_BASE:  pc_next = sr1_val;
      PC_MEM:   pc_next = mem_rdata;
      default:  pc_next = pc_q + 16'd1;
    endcase
  end

  reg16 #(.WIDTH(16)) pc (
    .clk(clk), .rst_n(rst_n), .ld(ld_pc), .in_data(pc_next), .out_data(pc_q)
  );

  reg16 #(.WIDTH(16)) ir (
    .clk(clk), .rst_n(rst_n), .ld(ld_ir), .in_data(mem_rdata), .out_data(ir_q)
  );

  reg16 #(.WIDTH(3), .RESET_VAL(CC_RESET)) cc (
    .clk(clk), .rst_n(rst_n), .ld(ld_cc), .in_data(nzp(wb_data)), .out_data(cc_q)
  );

  reg16 #(.WIDTH(16)) mar (
    .clk(clk), .rst_n(rst_n), .ld(ld_mar), .in_data(mem_rdata), .out_data(mar_q)
  );

  if (1) begin : regs
    for (genvar i = 0; i < 8; i++) begin : regs
      logic [15:0] out_data;
      reg16 #(.WIDTH(16)) r (
        .clk(clk), .rst_n(rst_n), .ld(ld_reg && (dr == 3'(i))),
        .in_data(wb_data), .out_data(out_data)
      );
      assign rf_q[i] = out_data;
    end
  end

  // Memory is deliberately outside the reset domain so preloaded programs survive reset
  if (1) begin : mem
    logic [15:0] mem [MEM_WORDS];
    always_ff @(posedge clk) begin
      if (mem_we) mem[mem_idx] <= sr_val;
    end
    assign mem_rdata = mem[mem_idx];
  end

  assign ir_out = ir_q;
  assign pc_out = pc_q;
  assign cc_out = cc_q;

endmodule

`default_nettype wire

// File: rtl/reg16.sv
// Generic load-enabled register with asynchronous active-low clear to a reset value.
`default_nettype none

module reg16 #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] out_data
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = ld ? in_data : data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_q <= RESET_VAL;
    else        data_q <= data_d;
  end

  assign out_data = data_q;

endmodule

`default_nettype wire

// File: rtl/control.sv
// LC-3 multi-cycle core top: FETCH/EXEC/IND/HALT sequencer driving the embedded datapath.
`default_nettype none

module control
  import lc3_pkg::*;
#(
  parameter int MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        halted,
  output logic [15:0] pc_o,
  output logic [15:0] ir_o
);

  state_e state_q, state_d;

  logic [15:0] ir, pc;
  logic [2:0]  cc;
  opcode_e     op;

  logic      ld_ir, ld_pc, ld_cc, ld_reg, ld_mar, mem_we, dr_r7;
  pc_sel_e   pc_sel;
  wb_sel_e   wb_sel;
  addr_sel_e addr_sel;
  alu_op_e   alu_op;

  datapath #(.MEM_WORDS(MEM_WORDS)) dp (
    .clk(clk), .rst_n(rst_n),
    .ld_ir(ld_ir), .ld_pc(ld_pc), .ld_cc(ld_cc), .ld_reg(ld_reg),
    .ld_mar(ld_mar), .mem_we(mem_we), .dr_r7(dr_r7),
    .pc_sel(pc_sel), .wb_sel(wb_sel), .addr_sel(addr_sel), .alu_op(alu_op),
    .ir_out(ir), .pc_out(pc), .cc_out(cc)
  );

  assign op = opcode_e'(ir[15:12]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    ld_ir    = 1'b0;
    ld_pc    = 1'b0;
    ld_cc    = 1'b0;
    ld_reg   = 1'b0;
    ld_mar   = 1'b0;
    mem_we   = 1'b0;
    dr_r7    = 1'b0;
    pc_sel   = PC_INC;
    wb_sel   = WB_ALU;
    addr_sel = A_PC;
    alu_op   = ALU_ADD;

    case (state_q)
      S_FETCH: begin
        ld_ir   = 1'b1;
        ld_pc   = 1'b1;
        state_d = S_EXEC;
      end

      S_EXEC: begin
        state_d = S_FETCH;
        case (op)
          OP_ADD: begin ld_reg = 1'b1; ld_cc = 1'b1; alu_op = ALU_ADD; end
          OP_AND: begin ld_reg = 1'b1; ld_cc = 1'b1; alu_op = ALU_AND; end
          OP_NOT: begin ld_reg = 1'b1; ld_cc = 1'b1; alu_op = ALU_NOT; end
          OP_BR: begin
            ld_pc  = |(ir[11:9] & cc);
            pc_sel = PC_OFF9;
          end
          OP_JMP: begin ld_pc = 1'b1; pc_sel = PC_BASE; end
          OP_JSR: begin
            ld_reg = 1'b1; dr_r7 = 1'b1; wb_sel = WB_PC;
            ld_pc  = 1'b1;
            pc_sel = ir[11] ? PC_OFF11 : PC_BASE;
          end
          OP_LD:  begin addr_sel = A_OFF9;  ld_reg = 1'b1; ld_cc = 1'b1; wb_sel = WB_MEM; end
          OP_LDR: begin addr_sel = A_BASE6; ld_reg = 1'b1; ld_cc = 1'b1; wb_sel = WB_MEM; end
          OP_LEA: begin ld_reg = 1'b1; wb_sel = WB_LEA; end
          OP_ST:  begin addr_sel = A_OFF9;  mem_we = 1'b1; end
          OP_STR: begin addr_sel = A_BASE6; mem_we = 1'b1; end
          OP_LDI, OP_STI: begin
            addr_sel = A_OFF9;
            ld_mar   = 1'b1;
            state_d  = S_IND;
          end
          OP_TRAP: begin
            if (ir[7:0] == TRAP_HALT) begin
              state_d = S_HALT;
            end else begin
              addr_sel = A_TRAP;
              ld_reg = 1'b1; dr_r7 = 1'b1; wb_sel = WB_PC;
              ld_pc  = 1'b1; pc_sel = PC_MEM;
            end
          end
          default: ;  // RTI and the reserved opcode retire as no-ops
        endcase
      end

      S_IND: begin
        addr_sel = A_MAR;
        state_d  = S_FETCH;
        if (op == OP_LDI) begin
          ld_reg = 1'b1; ld_cc = 1'b1; wb_sel = WB_MEM;
        end else begin
          mem_we = 1'b1;
        end
      end

      default: state_d = S_HALT;
    endcase
  end

  assign halted = (state_q == S_HALT);
  assign pc_o   = pc;
  assign ir_o   = ir;

endmodule

`default_nettype wire

// File: tb/tb_control.sv
// Self-checking bench for the LC-3 core: table of short programs plus multi-cycle corner sequences.
`default_nettype none

module tb_control;

  localparam int MW = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        halted;
  logic [15:0] pc_o, ir_o;

  control #(.MEM_WORDS(MW)) dut (
    .clk(clk), .rst_n(rst_n), .halted(halted), .pc_o(pc_o), .ir_o(ir_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [0:5][15:0] prog;
    logic [2:0]       ridx;
    logic [15:0]      rval;
    logic [2:0]       cc;
    logic [15:0]      pc;
    logic [7:0]       cyc;
  } vec_t;

  int checks = 0;
  int failures = 0;
  vec_t tbl [16];
  vec_t sb [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] rreg(input logic [2:0] i);
    case (i)
      3'd0: return dut.dp.regs.regs[0].out_data;
      3'd1: return dut.dp.regs.regs[1].out_data;
      3'd2: return dut.dp.regs.regs[2].out_data;
      3'd3: return dut.dp.regs.regs[3].out_data;
      3'd4: return dut.dp.regs.regs[4].out_data;
      3'd5: return dut.dp.regs.regs[5].out_data;
      3'd6: return dut.dp.regs.regs[6].out_data;
      default: return dut.dp.regs.regs[7].out_data;
    endcase
  endfunction

  function automatic vec_t mk(input logic [15:0] p0, p1, p2, p3, p4, p5,
                              input logic [2:0] ridx, input logic [15:0] rval,
                              input logic [2:0] cc, input logic [15:0] pc,
                              input logic [7:0] cyc);
    vec_t v;
    v.prog = {p0, p1, p2, p3, p4, p5};
    v.ridx = ridx; v.rval = rval; v.cc = cc; v.pc = pc; v.cyc = cyc;
    return v;
  endfunction

  // Holds the core in reset, clears memory, loads the program, releases on a falling edge
  task automatic start_prog(input logic [0:5][15:0] p);
    rst_n = 1'b0;
    #1;
    for (int a = 0; a < MW; a++) dut.dp.mem.mem[a] = 16'h0000;
    for (int a = 0; a < 6; a++)  dut.dp.mem.mem[a] = p[a];
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_to_halt(input int budget, output int cycles);
    cycles = 0;
    while (!halted && cycles < budget) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  initial begin
    int   cyc;
    vec_t e;

    tbl[0]  = mk(16'h1261, 16'h1261, 16'h1261, 16'hF025, 16'h0000, 16'h0000, 3'd1, 16'h0003, 3'b001, 16'h0004, 8'd8);
    tbl[1]  = mk(16'h5020, 16'h103F, 16'hF025, 16'h0000, 16'h0000, 16'h0000, 3'd0, 16'hFFFF, 3'b100, 16'h0003, 8'd6);
    tbl[2]  = mk(16'h2203, 16'h3203, 16'hF025, 16'h0000, 16'hBEEF, 16'h0000, 3'd1, 16'hBEEF, 3'b100, 16'h0003, 8'd6);
    tbl[3]  = mk(16'h14A7, 16'h54A5, 16'hF025, 16'h0000, 16'h0000, 16'h0000, 3'd2, 16'h0005, 3'b001, 16'h0003, 8'd6);
    tbl[4]  = mk(16'h14A7, 16'h94BF, 16'hF025, 16'h0000, 16'h0000, 16'h0000, 3'd2, 16'hFFF8, 3'b100, 16'h0003, 8'd6);
    tbl[5]  = mk(16'h1263, 16'h1641, 16'hF025, 16'h0000, 16'h0000, 16'h0000, 3'd3, 16'h0006, 3'b001, 16'h0003, 8'd6);
    tbl[6]  = mk(16'h1263, 16'h5864, 16'hF025, 16'h0000, 16'h0000, 16'h0000, 3'd4, 16'h0000, 3'b010, 16'h0003, 8'd6);
    tbl[7]  = mk(16'h103F, 16'hEA04, 16'hF025, 16'h0000, 16'h0000, 16'h0000, 3'd5, 16'h0006, 3'b100, 16'h0003, 8'd6);
    tbl[8]  = mk(16'h0402, 16'h1261, 16'h0000, 16'hF025, 16'h0000, 16'h0000, 3'd1, 16'h0000, 3'b010, 16'h0004, 8'd4);
    tbl[9]  = mk(16'h0BFF, 16'hF025, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 3'd0, 16'h0000, 3'b010, 16'h0002, 8'd4);
    tbl[10] = mk(16'h16E4, 16'hC0C0, 16'h1262, 16'h1262, 16'hF025, 16'h0000, 3'd1, 16'h0000, 3'b001, 16'h0005, 8'd6);
    tbl[11] = mk(16'hF005, 16'h0000, 16'h0000, 16'hF025, 16'h0000, 16'h0003, 3'd7, 16'h0001, 3'b010, 16'h0004, 8'd4);
    tbl[12] = mk(16'h1FE4, 16'h41C0, 16'h0000, 16'h0000, 16'hF025, 16'h0000, 3'd7, 16'h0002, 3'b001, 16'h0005, 8'd6);
    tbl[13] = mk(16'h3000, 16'h1261, 16'hF025, 16'h0000, 16'h0000, 16'h0000, 3'd1, 16'h0000, 3'b010, 16'h0003, 8'd6);
    tbl[14] = mk(16'h6C04, 16'hF025, 16'h0000, 16'h0000, 16'h7FFF, 16'h0000, 3'd6, 16'h7FFF, 3'b001, 16'h0002, 8'd4);
    tbl[15] = mk(16'h8000, 16'hD000, 16'hF025, 16'h0000, 16'h0000, 16'h0000, 3'd0, 16'h0000, 3'b010, 16'h0003, 8'd6);

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check("reset_pc", pc_o, 16'h0000);
    check("reset_ir", ir_o, 16'h0000);
    check("reset_cc", dut.dp.cc.out_data, 3'b010);
    check("reset_halted", halted, 1'b0);
    check("reset_r3", rreg(3'd3), 16'h0000);

    for (int i = 0; i < 16; i++) begin
      start_prog(tbl[i].prog);
      sb.push_back(tbl[i]);
      run_to_halt(100, cyc);
      e = sb.pop_front();
      check($sformatf("v%0d_halted", i), halted, 1'b1);
      check($sformatf("v%0d_reg", i), rreg(e.ridx), e.rval);
      check($sformatf("v%0d_cc", i), dut.dp.cc.out_data, e.cc);
      check($sformatf("v%0d_pc", i), pc_o, e.pc);
      check($sformatf("v%0d_cycles", i), cyc, 32'(e.cyc));
      if (i == 2)  check("st_mem5", dut.dp.mem.mem[5], 16'hBEEF);
      if (i == 13) check("st_overwrite_mem1", dut.dp.mem.mem[1], 16'h0000);
    end

    // Halt is absorbing
    step(3);
    check("halt_hold_pc", pc_o, 16'h0003);
    check("halt_hold", halted, 1'b1);

    // LDI: three cycles, result only after the IND edge
    start_prog({16'hA402, 16'hF025, 16'h0000, 16'h0010, 16'h0000, 16'h0000});
    dut.dp.mem.mem[16] = 16'h8000;
    step(2);
    check("ldi_not_yet", rreg(3'd2), 16'h0000);
    step(1);
    check("ldi_r2", rreg(3'd2), 16'h8000);
    check("ldi_cc", dut.dp.cc.out_data, 3'b100);
    check("ldi_pc", pc_o, 16'h0001);

    // STI through pointer
    start_prog({16'h1265, 16'hB202, 16'hF025, 16'h0000, 16'h0040, 16'h0000});
    run_to_halt(100, cyc);
    check("sti_mem40", dut.dp.mem.mem[64], 16'h0005);
    check("sti_cycles", cyc, 32'd7);

    // BRnp with CC=Z falls through, then JSR +5
    start_prog({16'h0BFF, 16'h4805, 16'h0000, 16'h0000, 16'h0000, 16'h0000});
    step(2);
    check("br_fall_pc", pc_o, 16'h0001);
    step(2);
    check("jsr_r7", rreg(3'd7), 16'h0002);
    check("jsr_pc", pc_o, 16'h0007);

    // Asynchronous reset in the middle of EXEC
    start_prog({16'h1261, 16'h1261, 16'h1261, 16'hF025, 16'h0000, 16'h0000});
    step(3);
    check("midexec_r1_before", rreg(3'd1), 16'h0001);
    #2 rst_n = 1'b0;
    #1;
    check("midexec_r1", rreg(3'd1), 16'h0000);
    check("midexec_pc", pc_o, 16'h0000);
    check("midexec_ir", ir_o, 16'h0000);
    check("midexec_cc", dut.dp.cc.out_data, 3'b010);
    check("midexec_mem0", dut.dp.mem.mem[0], 16'h1261);
    @(negedge clk);
    rst_n = 1'b1;
    run_to_halt(100, cyc);
    check("rerun_r1", rreg(3'd1), 16'h0003);
    check("rerun_cycles", cyc, 32'd8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
